// File: rtl/pcie_msg_q_scheduler.sv
// Message-queue drain scheduler: arbitrates pending queues and issues AXI read bursts.
// Define PCIE_MSG_SCHED_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pcie_msg_q_scheduler #(
  parameter int NUM_Q      = 15,
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic [NUM_Q-1:0]        i_intr_status,
  input  logic [NUM_Q*ADDR_W-1:0] i_q_init_addr,
  input  logic [NUM_Q*8-1:0]      i_q_len,
  output logic                    o_rd_req_valid,
  input  logic                    i_rd_req_ready,
  output logic [ADDR_W-1:0]       o_rd_req_addr,
  output logic [7:0]              o_rd_req_len,
  output logic [3:0]              o_rd_req_qid,
  input  logic                    i_rd_done,
  output logic [NUM_Q-1:0]        o_intr_clear,
  output logic                    o_busy,
  output logic [15:0]             o_served_cnt
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, GAP} state_t;

  localparam logic [8:0] MAX_B9 = 9'(MAX_BURST);

  state_t              state_reg;
  logic [3:0]          qid_reg;
  logic [7:0]          rem_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [7:0]          len_reg;
  logic                valid_reg;
  logic [NUM_Q-1:0]    clear_reg;
  logic                busy_reg;
  logic [15:0]         served_reg;
`ifndef PCIE_MSG_SCHED_STRICT_PRIO_EN
  logic [3:0]          ptr_reg;
`endif

  logic [ADDR_W-1:0]   q_addr [NUM_Q];
  logic [7:0]          q_len  [NUM_Q];

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_unpack
      assign q_addr[gi] = i_q_init_addr[gi*ADDR_W +: ADDR_W];
      assign q_len[gi]  = i_q_len[gi*8 +: 8];
    end
  endgenerate

  // AXI len (beats-1) for the next burst given the beats still owed; r is non-zero.
  function automatic logic [7:0] burst_len(input logic [7:0] r);
    if ({1'b0, r} > MAX_B9) return 8'(MAX_B9 - 9'd1);
    else                    return r - 8'd1;
  endfunction

  logic                grant_found;
  logic [3:0]          grant_idx;
  logic [4:0]          scan_sum;
  logic [3:0]          scan_idx;
  logic [ADDR_W-1:0]   burst_bytes;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_Q; i++) begin
`ifdef PCIE_MSG_SCHED_STRICT_PRIO_EN
      scan_sum = 5'(i);
`else
      // Rotate the scan so it starts at the pointer and wraps modulo NUM_Q.
      scan_sum = {1'b0, ptr_reg} + 5'(i);
      if (scan_sum >= 5'(NUM_Q)) scan_sum = scan_sum - 5'(NUM_Q);
`endif
      scan_idx = scan_sum[3:0];
      if (!grant_found && i_intr_status[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    burst_bytes = ADDR_W'((int'(len_reg) + 1) * BEAT_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      qid_reg    <= '0;
      rem_reg    <= '0;
      addr_reg   <= '0;
      len_reg    <= '0;
      valid_reg  <= 1'b0;
      clear_reg  <= '0;
      busy_reg   <= 1'b0;
      served_reg <= '0;
`ifndef PCIE_MSG_SCHED_STRICT_PRIO_EN
      ptr_reg    <= '0;
`endif
    end else begin
      clear_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (i_enable && grant_found) begin
            qid_reg  <= grant_idx;
            addr_reg <= q_addr[grant_idx];
            rem_reg  <= q_len[grant_idx];
            busy_reg <= 1'b1;
`ifndef PCIE_MSG_SCHED_STRICT_PRIO_EN
            ptr_reg  <= (grant_idx == 4'(NUM_Q - 1)) ? 4'd0 : grant_idx + 4'd1;
`endif
            if (q_len[grant_idx] != 8'd0) begin
              len_reg   <= burst_len(q_len[grant_idx]);
              valid_reg <= 1'b1;
              state_reg <= ISSUE;
            end else begin
              // Empty queue: acknowledge straight away without touching the bus.
              clear_reg  <= NUM_Q'(1) << grant_idx;
              served_reg <= (served_reg == 16'hFFFF) ? served_reg : served_reg + 16'd1;
              state_reg  <= CLEAR;
            end
          end
        end
        ISSUE: begin
          if (i_rd_req_ready) begin
            valid_reg <= 1'b0;
            rem_reg   <= rem_reg - (len_reg + 8'd1);
            addr_reg  <= addr_reg + burst_bytes;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (i_rd_done) begin
            if (rem_reg != 8'd0) begin
              len_reg   <= burst_len(rem_reg);
              valid_reg <= 1'b1;
              state_reg <= ISSUE;
            end else begin
              clear_reg  <= NUM_Q'(1) << qid_reg;
              served_reg <= (served_reg == 16'hFFFF) ? served_reg : served_reg + 16'd1;
              state_reg  <= CLEAR;
            end
          end
        end
        CLEAR: state_reg <= GAP;
        GAP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_rd_req_valid = valid_reg;
  assign o_rd_req_addr  = addr_reg;
  assign o_rd_req_len   = len_reg;
  assign o_rd_req_qid   = qid_reg;
  assign o_intr_clear   = clear_reg;
  assign o_busy         = busy_reg;
  assign o_served_cnt   = served_reg;

endmodule

// File: tb/tb_pcie_msg_q_scheduler.sv
// Bench for pcie_msg_q_scheduler: directed cases plus randomized queue sets against a
// transaction-level model of grant order, burst splitting and clear pulses.
module tb_pcie_msg_q_scheduler;

  localparam int NUM_Q = 15;
  localparam int ADDR_W = 32;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_enable = 1'b0;
  logic [NUM_Q-1:0]        i_intr_status = '0;
  logic [NUM_Q*ADDR_W-1:0] i_q_init_addr = '0;
  logic [NUM_Q*8-1:0]      i_q_len = '0;
  logic                    o_rd_req_valid;
  logic                    i_rd_req_ready = 1'b0;
  logic [ADDR_W-1:0]       o_rd_req_addr;
  logic [7:0]              o_rd_req_len;
  logic [3:0]              o_rd_req_qid;
  logic                    i_rd_done = 1'b0;
  logic [NUM_Q-1:0]        o_intr_clear;
  logic                    o_busy;
  logic [15:0]             o_served_cnt;

  pcie_msg_q_scheduler #(.NUM_Q(NUM_Q), .ADDR_W(ADDR_W), .BEAT_BYTES(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_intr_status(i_intr_status),
    .i_q_init_addr(i_q_init_addr), .i_q_len(i_q_len), .o_rd_req_valid(o_rd_req_valid),
    .i_rd_req_ready(i_rd_req_ready), .o_rd_req_addr(o_rd_req_addr), .o_rd_req_len(o_rd_req_len),
    .o_rd_req_qid(o_rd_req_qid), .i_rd_done(i_rd_done), .o_intr_clear(o_intr_clear),
    .o_busy(o_busy), .o_served_cnt(o_served_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_clr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  qid;
  } ev_t;

  ev_t         exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  bit          outstanding = 0;
  int          done_wait = 0;
  bit          prev_pend = 0;
  logic [31:0] sv_addr;
  logic [7:0]  sv_len;
  logic [3:0]  sv_qid;
  int          hold_cnt = 0;
  bit          force_spur = 0;
  bit          drop_en = 0;
  int          cyc_scn = 0;
  int          first_evt = -1;
  int          m_served = 0;
  int          m_ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_q(input int q, input logic [31:0] a, input int l);
    i_q_init_addr[q*32 +: 32] = a;
    i_q_len[q*8 +: 8] = 8'(l);
  endtask

  task automatic push_req(input logic [31:0] a, input int l, input int q);
    ev_t e;
    e.is_clr = 1'b0; e.addr = a; e.len = 8'(l); e.qid = 4'(q);
    exp_q.push_back(e);
  endtask

  // Completing a queue also moves the model's round-robin pointer past it.
  task automatic push_clr(input int q);
    ev_t e;
    e.is_clr = 1'b1; e.addr = '0; e.len = '0; e.qid = 4'(q);
    exp_q.push_back(e);
    m_ptr = (q + 1) % NUM_Q;
  endtask

  task automatic model_scn(input logic [NUM_Q-1:0] st);
    logic [NUM_Q-1:0] r;
    logic [31:0] a;
    int g, l, b, idx;
    r = st;
    while (r != 0) begin
      g = -1;
      for (int k = 0; k < NUM_Q; k++) begin
`ifdef PCIE_MSG_SCHED_STRICT_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % NUM_Q;
`endif
        if (g < 0 && r[idx]) g = idx;
      end
      l = int'(i_q_len[g*8 +: 8]);
      a = i_q_init_addr[g*32 +: 32];
      while (l > 0) begin
        b = (l > 16) ? 16 : l;
        push_req(a, b - 1, g);
        a = a + 32'(b * 32);
        l = l - b;
      end
      push_clr(g);
      r[g] = 1'b0;
    end
  endtask

  // One cycle of the read-engine / interrupt-block responder, sampled on the falling edge.
  task automatic tick();
    ev_t e;
    bit rdy;
    @(negedge clk);
    cyc_scn++;
    if (prev_pend) begin
      check("hold_valid", {31'd0, o_rd_req_valid}, 32'd1);
      check("hold_addr", o_rd_req_addr, sv_addr);
      check("hold_len", {24'd0, o_rd_req_len}, {24'd0, sv_len});
      check("hold_qid", {28'd0, o_rd_req_qid}, {28'd0, sv_qid});
    end
    prev_pend = 0;
    if (o_intr_clear != '0) begin
      if (first_evt < 0) first_evt = cyc_scn;
      if (exp_q.size() == 0) check("unexpected_clear", {17'd0, o_intr_clear}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("clear_mask", {17'd0, o_intr_clear}, e.is_clr ? (32'd1 << e.qid) : 32'd0);
        m_served++;
        check("served_cnt", {16'd0, o_served_cnt}, 32'(m_served));
      end
      i_intr_status = i_intr_status & ~o_intr_clear;
    end
    if (o_rd_req_valid && hold_cnt > 0) begin
      hold_cnt--;
      rdy = 0;
    end else begin
      rdy = ($urandom_range(0, 3) != 0);
    end
    i_rd_req_ready = rdy;
    i_rd_done = 1'b0;
    if (outstanding) begin
      if (done_wait == 0) begin
        i_rd_done = 1'b1;
        outstanding = 0;
      end else done_wait--;
    end else if (o_rd_req_valid && !rdy && (force_spur || $urandom_range(0, 3) == 0)) begin
      i_rd_done = 1'b1;
    end else if (!o_rd_req_valid && $urandom_range(0, 4) == 0) begin
      i_rd_done = 1'b1;
    end
    if (o_rd_req_valid) begin
      if (first_evt < 0) first_evt = cyc_scn;
      if (rdy) begin
        if (exp_q.size() == 0) check("unexpected_req", {31'd0, o_rd_req_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("req_kind", {31'd0, e.is_clr}, 32'd0);
          check("req_addr", o_rd_req_addr, e.addr);
          check("req_len", {24'd0, o_rd_req_len}, {24'd0, e.len});
          check("req_qid", {28'd0, o_rd_req_qid}, {28'd0, e.qid});
        end
        outstanding = 1;
        done_wait = $urandom_range(0, 3);
        set_q(int'(o_rd_req_qid), $urandom, $urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) i_intr_status[o_rd_req_qid] = 1'b0;
        if (drop_en) i_enable = 1'b0;
      end else begin
        prev_pend = 1;
        sv_addr = o_rd_req_addr;
        sv_len = o_rd_req_len;
        sv_qid = o_rd_req_qid;
      end
    end
  endtask

  task automatic run_scn(input string tag);
    int guard;
    guard = 0;
    cyc_scn = 0;
    first_evt = -1;
    do begin
      tick();
      guard++;
    end while (!(exp_q.size() == 0 && !o_busy && !outstanding) && guard < 3000);
    check({tag, "_timeout"}, 32'(guard < 3000), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    $display("scenario %s: %0d cycles, first event at cycle %0d, served %0d", tag, guard, first_evt, o_served_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, o_rd_req_valid}, 32'd0);
    check({tag, "_addr"}, o_rd_req_addr, 32'd0);
    check({tag, "_len"}, {24'd0, o_rd_req_len}, 32'd0);
    check({tag, "_qid"}, {28'd0, o_rd_req_qid}, 32'd0);
    check({tag, "_clear"}, {17'd0, o_intr_clear}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_served"}, {16'd0, o_served_cnt}, 32'd0);
  endtask

  initial begin
    logic [NUM_Q-1:0] st;
    int guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    i_enable = 1'b1;

    set_q(3, 32'h200, 5);
    i_intr_status = 15'h0008;
    push_req(32'h200, 4, 3); push_clr(3);
    run_scn("q3_len5");
    check("q3_latency", 32'(first_evt), 32'd1);

    set_q(1, 32'h1000, 40);
    i_intr_status = 15'h0002;
    push_req(32'h1000, 15, 1); push_req(32'h1200, 15, 1); push_req(32'h1400, 7, 1); push_clr(1);
    run_scn("q1_len40");

    set_q(2, 32'h300, 0);
    i_intr_status = 15'h0004;
    push_clr(2);
    run_scn("q2_len0");
    check("q2_latency", 32'(first_evt), 32'd1);

    set_q(4, 32'h4000, 20);
    i_intr_status = 15'h0010;
    push_req(32'h4000, 15, 4); push_req(32'h4200, 3, 4); push_clr(4);
    hold_cnt = 10; force_spur = 1;
    run_scn("ready_hold");
    force_spur = 0;
    check("hold_consumed", 32'(hold_cnt), 32'd0);

    set_q(6, 32'h600, 3);
    i_intr_status = 15'h0040;
    push_req(32'h600, 2, 6);
    guard = 0;
    while (!outstanding && guard < 50) begin
      tick();
      guard++;
    end
    check("rst_reach_wait", 32'(outstanding), 32'd1);
    i_rd_done = 1'b0;
    @(negedge clk);
    check("wait_busy", {31'd0, o_busy}, 32'd1);
    check("wait_valid", {31'd0, o_rd_req_valid}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_in_wait");
    rst_n = 1'b1;
    i_intr_status = '0;
    outstanding = 0; prev_pend = 0; exp_q.delete(); m_served = 0; m_ptr = 0;
    i_rd_done = 1'b1;
    @(negedge clk);
    i_rd_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("post_rst_clear", {17'd0, o_intr_clear}, 32'd0);
      check("post_rst_busy", {31'd0, o_busy}, 32'd0);
      @(negedge clk);
    end

    set_q(0, 32'h100, 1); set_q(5, 32'h500, 1); set_q(14, 32'hE00, 1);
    i_intr_status = 15'h4021;
    push_req(32'h100, 0, 0); push_clr(0);
    push_req(32'h500, 0, 5); push_clr(5);
    push_req(32'hE00, 0, 14); push_clr(14);
    run_scn("rr_0_5_14");
    set_q(0, 32'h100, 1); set_q(5, 32'h500, 1);
    i_intr_status = 15'h0021;
    push_req(32'h100, 0, 0); push_clr(0);
    push_req(32'h500, 0, 5); push_clr(5);
    run_scn("rr_0_5");

    set_q(6, 32'h660, 1); set_q(7, 32'h770, 1);
    i_intr_status = 15'h00C0;
    push_req(32'h660, 0, 6); push_clr(6);
    drop_en = 1;
    run_scn("enable_drop");
    drop_en = 0;
    repeat (10) tick();
    check("disabled_idle", {31'd0, o_busy}, 32'd0);
    i_enable = 1'b1;
    push_req(32'h770, 0, 7); push_clr(7);
    run_scn("enable_resume");

    for (int n = 0; n < 25; n++) begin
      st = NUM_Q'($urandom);
      for (int q = 0; q < NUM_Q; q++)
        set_q(q, $urandom, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40));
      model_scn(st);
      i_intr_status = st;
      run_scn($sformatf("random_%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_msg_q_scheduler.md
Name: pcie_msg_q_scheduler

Overview:
Drains assembled-message queues out of the message SRAM. It watches the per-queue interrupt status bits raised by the message receiver and picks one pending queue by round-robin. It then issues one or more AXI-read burst requests to the read engine (which fronts pcie_axi_to_sram) from that queue's initial address. When the last burst completes, it pulses the queue's interrupt-clear bit. It sits between the SFR/interrupt block and the AXI read master.

Parameters:
NUM_Q, 15, number of message queues (max 16)
ADDR_W, 32, read address width
BEAT_BYTES, 32, bytes per 256-bit beat
MAX_BURST, 16, max beats per issued burst (1..256)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
i_enable  input  1  scheduler enable; sampled only in IDLE
i_intr_status  input  NUM_Q  per-queue message-ready (Q_INTR_STATUS_0)
i_q_init_addr  input  NUM_Q*ADDR_W  flattened queue base byte addresses; queue q at [q*ADDR_W +: ADDR_W]
i_q_len  input  NUM_Q*8  flattened pending beats per queue (0..255); queue q at [q*8 +: 8]
o_rd_req_valid  output  1  burst request valid
i_rd_req_ready  input  1  read engine accepts request
o_rd_req_addr  output  ADDR_W  burst start byte address
o_rd_req_len  output  8  AXI len (beats-1)
o_rd_req_qid  output  4  queue being served
i_rd_done  input  1  one-cycle pulse: last beat (rlast) of the outstanding burst accepted
o_intr_clear  output  NUM_Q  one-cycle one-hot clear pulse (Q_INTR_CLEAR_0)
o_busy  output  1  high in any state except IDLE
o_served_cnt  output  16  completed queues, saturating at 0xFFFF

Behaviour:
- Reset (rst_n low at posedge):
  - State = IDLE; RR pointer = 0.
  - All outputs 0: valid, addr, len, qid, clear, busy, served_cnt.
  - Any in-flight request is abandoned.
  - i_rd_done is ignored in every state except WAIT.
- States: IDLE, ISSUE, WAIT, CLEAR, GAP.
- IDLE:
  - Condition: i_enable=1 and (i_intr_status != 0).
  - Grant = first set bit at or after RR pointer, wrapping modulo NUM_Q.
  - Latch grant qid, base address, and remaining beats rem = i_q_len[qid].
  - rem != 0: go to ISSUE. rem == 0: go to CLEAR (no read issued).
  - RR pointer = (grant+1) mod NUM_Q.
- ISSUE:
  - o_rd_req_valid=1; addr = current address; len = min(rem, MAX_BURST)-1; qid = grant.
  - All request fields are held stable while valid=1 and ready=0.
  - On valid&&ready: rem -= burst beats; addr += burst beats*BEAT_BYTES (mod 2^ADDR_W); valid drops next cycle; go to WAIT.
- WAIT:
  - On i_rd_done: rem != 0 -> ISSUE; rem == 0 -> CLEAR.
  - Only one burst is ever outstanding.
- CLEAR:
  - o_intr_clear = 1<<qid for exactly one cycle.
  - served_cnt += 1, saturating.
  - Go to GAP.
- GAP:
  - One idle cycle so the status bit can fall before re-arbitration; then IDLE.
- Latency:
  - Pending bit seen in IDLE at cycle T -> o_rd_req_valid high at T+1.
  - Zero-length queue: o_intr_clear high at T+1.
- i_enable low mid-operation: the current queue completes fully; no new grant is made.
- Status bit of the queue being served dropping mid-service: ignored; service completes and clear is still pulsed.
- i_q_len / i_q_init_addr are sampled only at grant; later changes have no effect on the current queue.
- Status bits at index >= NUM_Q do not exist; the pointer never exceeds NUM_Q-1.

Optional Feature:
PCIE_MSG_SCHED_STRICT_PRIO_EN:
- Defined: fixed priority, lowest set index always wins; the RR pointer is removed.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Queue 3 only: status=0x0008, len=5, base 0x200 -> one request (addr 0x200, len 4, qid 3); after done, o_intr_clear=0x0008 for one cycle; served_cnt=1.
- Queue 1: len=40, base 0x1000, MAX_BURST=16 -> three requests:
  - addr 0x1000 len 15
  - addr 0x1200 len 15
  - addr 0x1400 len 7
  - Then one clear pulse 0x0002, only after the third done.
- Status bits 0, 5, 14 set together, each len 1:
  - Grant order 0, 5, 14.
  - Then set bits 5 and 0 again -> order 0, 5.
  - With strict macro and bit 0 re-set each time: 0 always wins.
- Queue 2, len=0 -> no o_rd_req_valid; o_intr_clear=0x0004 one cycle after detection.
- i_rd_req_ready held low 10 cycles with an i_rd_done pulse injected during ISSUE -> valid/addr/len/qid stable throughout; done pulse ignored; state advances only on handshake.
- rst_n low during WAIT -> next cycle all outputs 0, served_cnt=0; a later i_rd_done produces no clear pulse.
